// File: rtl/decode_ctrl_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decode_ctrl_pipe_pkg
// Description : Shared opcode, load/store, RV32M and control-record
//               definitions for the registered decode controller.
// Revision    : 1.0 - initial release
// ============================================================================
package decode_ctrl_pipe_pkg;

    localparam logic [6:0] OPCODE_RTYPE = 7'b0110011;
    localparam logic [6:0] OPCODE_ITYPE = 7'b0010011;
    localparam logic [6:0] OPCODE_ILOAD = 7'b0000011;
    localparam logic [6:0] OPCODE_STYPE = 7'b0100011;
    localparam logic [6:0] OPCODE_BTYPE = 7'b1100011;
    localparam logic [6:0] OPCODE_UTYPE = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC = 7'b0010111;
    localparam logic [6:0] OPCODE_JTYPE = 7'b1101111;
    localparam logic [6:0] OPCODE_IJALR = 7'b1100111;

    localparam logic [2:0] LOAD_DEF = 3'd0;
    localparam logic [2:0] LOAD_LB  = 3'd1;
    localparam logic [2:0] LOAD_LH  = 3'd2;
    localparam logic [2:0] LOAD_LW  = 3'd3;
    localparam logic [2:0] LOAD_LBU = 3'd4;
    localparam logic [2:0] LOAD_LHU = 3'd5;

    localparam logic [1:0] STORE_DEF = 2'd0;
    localparam logic [1:0] STORE_SB  = 2'd1;
    localparam logic [1:0] STORE_SH  = 2'd2;
    localparam logic [1:0] STORE_SW  = 2'd3;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;
    localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

    typedef struct packed {
        logic       alu_src;
        logic       mem_write;
        logic [2:0] load_type;
        logic [1:0] store_type;
        logic       wb_load;
        logic       wb_reg_file;
        logic       is_muldiv;
        logic [2:0] md_op;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       illegal;
    } ctrl_t;

    function automatic ctrl_t ctrl_reset();
        ctrl_t c;
        c            = '0;
        c.load_type  = LOAD_DEF;
        c.store_type = STORE_DEF;
        return c;
    endfunction

    // DIV, DIVU, REM and REMU all have funct3[2] set; the MUL group does not.
    function automatic logic is_div_op(input ctrl_t c);
        return c.is_muldiv & c.md_op[2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_ctrl_comb.sv
`default_nettype none
// ============================================================================
// Module      : decode_ctrl_comb
// Description : Pure combinational RV32I/M decode into EX/MEM/WB control,
//               illegal-encoding detection and source-register usage.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_ctrl_comb
    import decode_ctrl_pipe_pkg::*;
#(
    parameter int M_EXT = 1
) (
    input  logic [31:0] i_instr,
    output ctrl_t       o_ctrl,
    output logic        o_rs1_used,
    output logic        o_rs2_used
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic       w_illegal;
    logic       w_wb_en;
    ctrl_t      w_ctrl;

    assign w_opcode = i_instr[6:0];
    assign w_funct3 = i_instr[14:12];
    assign w_funct7 = i_instr[31:25];

    always_comb begin
        w_illegal         = 1'b0;
        w_wb_en           = 1'b0;
        w_ctrl            = ctrl_reset();
        w_ctrl.rd         = i_instr[11:7];
        w_ctrl.rs1        = i_instr[19:15];
        w_ctrl.rs2        = i_instr[24:20];
        case (w_opcode)
            OPCODE_RTYPE: begin
                w_wb_en = 1'b1;
                if ((w_funct7 == FUNCT7_MEXT) && (M_EXT != 0)) begin
                    w_ctrl.is_muldiv = 1'b1;
                    w_ctrl.md_op     = w_funct3;
                end else if ((w_funct7 != FUNCT7_BASE) && (w_funct7 != FUNCT7_ALT)) begin
                    w_illegal = 1'b1;
                end
            end
            OPCODE_ITYPE, OPCODE_IJALR, OPCODE_UTYPE, OPCODE_AUIPC: begin
                w_ctrl.alu_src = 1'b1;
                w_wb_en        = 1'b1;
            end
            OPCODE_ILOAD: begin
                w_ctrl.alu_src = 1'b1;
                w_ctrl.wb_load = 1'b1;
                w_wb_en        = 1'b1;
                case (w_funct3)
                    3'b000:  w_ctrl.load_type = LOAD_LB;
                    3'b001:  w_ctrl.load_type = LOAD_LH;
                    3'b010:  w_ctrl.load_type = LOAD_LW;
                    3'b100:  w_ctrl.load_type = LOAD_LBU;
                    3'b101:  w_ctrl.load_type = LOAD_LHU;
                    default: w_illegal        = 1'b1;
                endcase
            end
            OPCODE_STYPE: begin
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.mem_write = 1'b1;
                case (w_funct3)
                    3'b000:  w_ctrl.store_type = STORE_SB;
                    3'b001:  w_ctrl.store_type = STORE_SH;
                    3'b010:  w_ctrl.store_type = STORE_SW;
                    default: w_illegal         = 1'b1;
                endcase
            end
            OPCODE_JTYPE: w_wb_en   = 1'b1;
            OPCODE_BTYPE: w_wb_en   = 1'b0;
            default:      w_illegal = 1'b1;
        endcase

        // An illegal entry still flows down the pipe but must have no side effects.
        if (w_illegal) begin
            w_ctrl.mem_write  = 1'b0;
            w_ctrl.wb_load    = 1'b0;
            w_ctrl.load_type  = LOAD_DEF;
            w_ctrl.store_type = STORE_DEF;
            w_ctrl.is_muldiv  = 1'b0;
            w_ctrl.md_op      = 3'b000;
        end
        w_ctrl.illegal     = w_illegal;
        w_ctrl.wb_reg_file = w_wb_en & ~w_illegal & (w_ctrl.rd != 5'd0);
    end

    assign o_ctrl     = w_ctrl;
    assign o_rs1_used = (w_opcode != OPCODE_UTYPE) && (w_opcode != OPCODE_AUIPC) &&
                        (w_opcode != OPCODE_JTYPE);
    assign o_rs2_used = (w_opcode == OPCODE_RTYPE) || (w_opcode == OPCODE_STYPE) ||
                        (w_opcode == OPCODE_BTYPE);

endmodule
`default_nettype wire

// File: rtl/decode_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module      : decode_ctrl_pipe
// Description : Registered ID/EX control stage with valid/ready handshake,
//               load-use stall (LOAD_USE_STALL_EN) and divider occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_ctrl_pipe
    import decode_ctrl_pipe_pkg::*;
#(
    parameter int M_EXT      = 1,
    parameter int DIV_CYCLES = 33,
    parameter int CNT_W      = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic        flush,
    input  logic        ex_ready,
    output logic        out_valid,
    output logic        out_alu_src,
    output logic        out_mem_write,
    output logic [2:0]  out_load_type,
    output logic [1:0]  out_store_type,
    output logic        out_wb_load,
    output logic        out_wb_reg_file,
    output logic        out_is_muldiv,
    output logic [2:0]  out_md_op,
    output logic [4:0]  out_rd,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic        out_illegal,
    output logic        md_busy
);

    localparam logic [CNT_W-1:0] c_DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    ctrl_t            w_dec;
    logic             w_rs1_used;
    logic             w_rs2_used;
    logic             w_hazard;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_handoff;
    ctrl_t            r_ctrl;
    logic             r_valid;
    logic [CNT_W-1:0] r_cnt;

    decode_ctrl_comb #(
        .M_EXT (M_EXT)
    ) u_comb (
        .i_instr    (instr),
        .o_ctrl     (w_dec),
        .o_rs1_used (w_rs1_used),
        .o_rs2_used (w_rs2_used)
    );

`ifdef LOAD_USE_STALL_EN
    assign w_hazard = r_valid & r_ctrl.wb_load & (r_ctrl.rd != 5'd0) &
                      ((w_rs1_used & (w_dec.rs1 == r_ctrl.rd)) |
                       (w_rs2_used & (w_dec.rs2 == r_ctrl.rd)));
`else
    // An external hazard unit owns load-use stalls in this build.
    logic w_unused_rs;
    assign w_hazard    = 1'b0;
    assign w_unused_rs = w_rs1_used ^ w_rs2_used;
`endif

    assign md_busy    = (r_cnt != '0);
    assign w_in_ready = (~r_valid | ex_ready) & ~w_hazard & ~md_busy & ~flush;
    assign w_accept   = in_valid & w_in_ready;
    assign w_handoff  = r_valid & ex_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_ctrl  <= ctrl_reset();
            r_cnt   <= '0;
        end else begin
            if (flush) begin
                r_valid <= 1'b0;
            end else if (ex_ready || !r_valid) begin
                r_valid <= w_accept;
                if (w_accept) begin
                    r_ctrl <= w_dec;
                end
            end

            // A handoff completing alongside a flush still starts the divider.
            if (w_handoff && is_div_op(r_ctrl)) begin
                r_cnt <= c_DIV_LOAD;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - c_CNT_ONE;
            end
        end
    end

    assign in_ready        = w_in_ready;
    assign out_valid       = r_valid;
    assign out_alu_src     = r_ctrl.alu_src;
    assign out_mem_write   = r_ctrl.mem_write;
    assign out_load_type   = r_ctrl.load_type;
    assign out_store_type  = r_ctrl.store_type;
    assign out_wb_load     = r_ctrl.wb_load;
    assign out_wb_reg_file = r_ctrl.wb_reg_file;
    assign out_is_muldiv   = r_ctrl.is_muldiv;
    assign out_md_op       = r_ctrl.md_op;
    assign out_rd          = r_ctrl.rd;
    assign out_rs1         = r_ctrl.rs1;
    assign out_rs2         = r_ctrl.rs2;
    assign out_illegal     = r_ctrl.illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_ctrl_pipe
// Description : Scoreboard bench for decode_ctrl_pipe (default parameters).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_ctrl_pipe;

    localparam int DIV_CYCLES = 33;
`ifdef LOAD_USE_STALL_EN
    localparam int LU_GAP = 2;
`else
    localparam int LU_GAP = 1;
`endif

    localparam logic [31:0] I_NOP   = 32'h00000013;
    localparam logic [31:0] I_LW    = 32'h00002083;
    localparam logic [31:0] I_ADD   = 32'h00108133;
    localparam logic [31:0] I_DIV   = 32'h0220C1B3;
    localparam logic [31:0] I_ADDI5 = 32'h00100293;
    localparam logic [31:0] I_ADDI6 = 32'h00200313;
    localparam logic [31:0] I_BADST = 32'h00003023;

    typedef struct packed {
        logic       alu_src;
        logic       mem_write;
        logic [2:0] load_type;
        logic [1:0] store_type;
        logic       wb_load;
        logic       wb_reg_file;
        logic       is_muldiv;
        logic [2:0] md_op;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       illegal;
        logic       rs1_used;
        logic       rs2_used;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = 32'h0;
    logic        flush = 1'b0;
    logic        ex_ready = 1'b0;
    logic        out_valid, out_alu_src, out_mem_write, out_wb_load, out_wb_reg_file;
    logic        out_is_muldiv, out_illegal, md_busy;
    logic [2:0]  out_load_type, out_md_op;
    logic [1:0]  out_store_type;
    logic [4:0]  out_rd, out_rs1, out_rs2;

    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   busy_seen = 0;
    logic m_valid = 1'b0;
    int   m_cnt = 0;
    exp_t q[$];

    decode_ctrl_pipe dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .instr           (instr),
        .flush           (flush),
        .ex_ready        (ex_ready),
        .out_valid       (out_valid),
        .out_alu_src     (out_alu_src),
        .out_mem_write   (out_mem_write),
        .out_load_type   (out_load_type),
        .out_store_type  (out_store_type),
        .out_wb_load     (out_wb_load),
        .out_wb_reg_file (out_wb_reg_file),
        .out_is_muldiv   (out_is_muldiv),
        .out_md_op       (out_md_op),
        .out_rd          (out_rd),
        .out_rs1         (out_rs1),
        .out_rs2         (out_rs2),
        .out_illegal     (out_illegal),
        .md_busy         (md_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference decode, written from the instruction-set tables.
    function automatic exp_t ref_dec(input logic [31:0] ins);
        exp_t       e;
        logic       wb;
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = ins[14:12];
        f7 = ins[31:25];
        e = '0;
        e.rd = ins[11:7];
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        e.rs1_used = 1'b1;
        wb = 1'b0;
        case (ins[6:0])
            7'b0110011: begin
                wb = 1'b1; e.rs2_used = 1'b1;
                if (f7 == 7'b0000001) begin e.is_muldiv = 1'b1; e.md_op = f3; end
                else if (f7 != 7'b0000000 && f7 != 7'b0100000) e.illegal = 1'b1;
            end
            7'b0010011, 7'b1100111: begin e.alu_src = 1'b1; wb = 1'b1; end
            7'b0000011: begin
                e.alu_src = 1'b1; wb = 1'b1;
                case (f3)
                    3'd0: e.load_type = 3'd1;
                    3'd1: e.load_type = 3'd2;
                    3'd2: e.load_type = 3'd3;
                    3'd4: e.load_type = 3'd4;
                    3'd5: e.load_type = 3'd5;
                    default: e.illegal = 1'b1;
                endcase
                e.wb_load = !e.illegal;
            end
            7'b0100011: begin
                e.alu_src = 1'b1; e.rs2_used = 1'b1;
                case (f3)
                    3'd0: e.store_type = 2'd1;
                    3'd1: e.store_type = 2'd2;
                    3'd2: e.store_type = 2'd3;
                    default: e.illegal = 1'b1;
                endcase
                e.mem_write = !e.illegal;
            end
            7'b1100011: e.rs2_used = 1'b1;
            7'b0110111, 7'b0010111: begin e.alu_src = 1'b1; wb = 1'b1; e.rs1_used = 1'b0; end
            7'b1101111: begin wb = 1'b1; e.rs1_used = 1'b0; end
            default: e.illegal = 1'b1;
        endcase
        e.wb_reg_file = wb && !e.illegal && (e.rd != 5'd0);
        return e;
    endfunction

    task automatic cycle(input logic v, input logic [31:0] ins, input logic exr,
                         input logic fl, output logic acc);
        exp_t d;
        exp_t h;
        logic haz;
        logic rdy;
        @(negedge clk);
        in_valid = v; instr = ins; ex_ready = exr; flush = fl;
        #1;
        d = ref_dec(ins);
        h = '0;
        if (m_valid && q.size() > 0) h = q[0];
        haz = 1'b0;
`ifdef LOAD_USE_STALL_EN
        haz = m_valid && h.wb_load && (h.rd != 5'd0) &&
              ((d.rs1_used && d.rs1 == h.rd) || (d.rs2_used && d.rs2 == h.rd));
`endif
        rdy = (!m_valid || exr) && !haz && (m_cnt == 0) && !fl;
        acc = v && rdy;
        if (md_busy === 1'b1) busy_seen++;
        check("in_ready", in_ready, rdy);
        check("md_busy", md_busy, m_cnt != 0);
        check("out_valid", out_valid, m_valid);
        if (m_valid) begin
            check("ctrl", {out_alu_src, out_mem_write, out_load_type, out_store_type,
                           out_wb_load, out_wb_reg_file, out_illegal},
                          {h.alu_src, h.mem_write, h.load_type, h.store_type,
                           h.wb_load, h.wb_reg_file, h.illegal});
            check("muldiv", {out_is_muldiv, out_md_op}, {h.is_muldiv, h.md_op});
            check("regs", {out_rd, out_rs1, out_rs2}, {h.rd, h.rs1, h.rs2});
        end
        @(posedge clk);
        if (m_valid && exr && h.is_muldiv && h.md_op[2]) m_cnt = DIV_CYCLES - 1;
        else if (m_cnt != 0) m_cnt--;
        if (m_valid && (exr || fl) && q.size() > 0) void'(q.pop_front());
        if (fl) m_valid = 1'b0;
        else if (exr || !m_valid) begin
            if (acc) begin q.push_back(d); m_valid = 1'b1; end
            else m_valid = 1'b0;
        end
        cyc++;
    endtask

    task automatic send(input logic [31:0] ins, output int acc_cyc);
        logic a;
        int   n;
        a = 1'b0;
        n = 0;
        while (!a && n < 100) begin
            cycle(1'b1, ins, 1'b1, 1'b0, a);
            n++;
        end
        if (!a) begin
            n_fail++;
            $display("FAIL send_timeout: instr %08h not accepted in %0d cycles", ins, n);
        end
        acc_cyc = cyc;
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) cycle(1'b0, I_NOP, 1'b1, 1'b0, a);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; ex_ready = 1'b0;
        @(posedge clk);
        m_valid = 1'b0; m_cnt = 0; q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_outs", {out_valid, out_alu_src, out_mem_write, out_load_type,
                           out_store_type, out_wb_load, out_wb_reg_file, out_is_muldiv,
                           out_md_op, out_rd, out_rs1, out_rs2, out_illegal}, 64'd0);
        check("rst_load_type", out_load_type, 3'd0);
        check("rst_md_busy", md_busy, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
    endtask

    logic [31:0] misc [18] = '{
        32'h402081B3, 32'h02208233, 32'h0220F2B3, 32'h123453B7, 32'h00001417,
        32'h008000EF, 32'h00008067, 32'h00208463, 32'h00008403, 32'h0000D483,
        32'h00208023, 32'h00209023, 32'h0000B503, 32'h10208233, 32'h0000007F,
        32'h00100013, 32'h0000A583, 32'h00B12023
    };

    initial begin
        int   c0;
        int   c1;
        logic a;
        do_reset();

        send(I_LW, c0);
        send(I_ADD, c1);
        check("load_use_gap", c1 - c0, LU_GAP);
        idle(3);

        busy_seen = 0;
        send(I_DIV, c0);
        idle(1);
        send(I_ADDI5, c1);
        check("div_accept_gap", c1 - c0, DIV_CYCLES + 1);
        check("div_busy_cycles", busy_seen, DIV_CYCLES - 1);
        idle(2);

        send(I_BADST, c0);
        idle(2);

        send(I_ADDI5, c0);
        repeat (5) cycle(1'b1, I_ADDI6, 1'b0, 1'b0, a);
        cycle(1'b1, I_ADDI6, 1'b1, 1'b0, a);
        idle(2);

        send(I_DIV, c0);
        cycle(1'b1, I_ADDI5, 1'b1, 1'b0, a);
        cycle(1'b1, I_ADDI6, 1'b0, 1'b0, a);
        cycle(1'b1, I_ADDI6, 1'b0, 1'b1, a);
        idle(3);
        do_reset();

        send(I_DIV, c0);
        cycle(1'b0, I_NOP, 1'b1, 1'b1, a);
        idle(DIV_CYCLES + 2);

        foreach (misc[i]) begin
            send(misc[i], c0);
            if ($urandom_range(0, 1) == 1) cycle(1'b0, I_NOP, 1'b0, 1'b0, a);
        end
        idle(DIV_CYCLES + 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decode_ctrl_pipe.md
Name: decode_ctrl_pipe

Overview:
Registered, handshaked successor to the combinational decode controller. It decodes a 32-bit RV32I/M instruction into EX/MEM/WB control fields and holds them in a single-entry ID/EX control register with valid/ready flow control. It adds three things the combinational decoder lacks: RV32M op decoding, load-use stall generation, and a multi-cycle divider occupancy counter. It sits between the IF/ID register and the execute stage.

Parameters:
M_EXT, 1, 1 = decode RV32M (funct7 = 0000001) as mul/div; 0 = flag those encodings illegal.
DIV_CYCLES, 33, EX occupancy in cycles of DIV/DIVU/REM/REMU (legal range 1..63); MUL* ops take 1 cycle.
CNT_W, 6, width of the divider occupancy counter; must hold DIV_CYCLES-1.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous reset, active low
in_valid  in  1  instr is valid
in_ready  out  1  stage accepts instr this cycle
instr  in  32  raw instruction
flush  in  1  kill the held entry (branch/jump redirect)
ex_ready  in  1  execute stage accepts the held entry
out_valid  out  1  held entry valid
out_alu_src  out  1  immediate operand select
out_mem_write  out  1  store
out_load_type  out  3  LOAD_* encoding
out_store_type  out  2  STORE_* encoding
out_wb_load  out  1  writeback from memory
out_wb_reg_file  out  1  register write enable
out_is_muldiv  out  1  RV32M op
out_md_op  out  3  funct3 of the RV32M op
out_rd, out_rs1, out_rs2  out  5 each  register indices
out_illegal  out  1  unsupported encoding
md_busy  out  1  divider occupancy counter nonzero

Behaviour:
- Reset (rst_n = 0 at a clk edge): every out_* = 0, out_load_type = LOAD_DEF, out_store_type = STORE_DEF, counter = 0, md_busy = 0.
- Decode is combinational from instr; fields are registered on accept. Latency is 1 cycle from accept to out_valid.
- Control field decode:
  - alu_src set for ITYPE, ILOAD, STYPE, UTYPE, AUIPC, IJALR.
  - wb_reg_file set for RTYPE, UTYPE, ITYPE, ILOAD, IJALR, AUIPC, JTYPE.
  - Never set on illegal or when rd = 0.
- Illegal: unknown opcode; load funct3 in {011, 11x}; store funct3 not in {000, 001, 010}; RTYPE funct7 not in {0000000, 0100000, 0000001 when M_EXT}. An illegal entry still flows as valid with mem_write = 0, wb_reg_file = 0, wb_load = 0, out_illegal = 1.
- rs1 is "used" for all opcodes except UTYPE, AUIPC and JTYPE. rs2 is "used" for RTYPE, STYPE and BTYPE only.
- hazard = out_valid & out_wb_load & out_rd != 0 & ((rs1 used & rs1 == out_rd) | (rs2 used & rs2 == out_rd)), computed from the incoming instr.
- in_ready = (!out_valid | ex_ready) & !hazard & !md_busy & !flush.
- Register update priority: reset > flush > (ex_ready or !out_valid). On update:
  - accept → load the decoded fields, out_valid = 1;
  - otherwise → out_valid = 0 (bubble).
  - While out_valid & !ex_ready the register holds, stable.
- Load-use: the load leaves, a bubble enters, and the dependent instruction is accepted on the next cycle. Exactly one bubble.
- Divider counter:
  - On handoff (out_valid & ex_ready) of a DIV/DIVU/REM/REMU, load DIV_CYCLES-1.
  - Otherwise decrement when nonzero.
  - md_busy = counter != 0. With DIV_CYCLES = 1, no stall.
- Flush clears out_valid next edge and forces in_ready = 0 that cycle. It does not clear the counter (the divide is older than the redirect).
- Simultaneous flush and handoff: the handoff completes (EX sees it) and the counter loads if it is a divide; the entry is then invalidated.

Optional Feature:
LOAD_USE_STALL_EN
- Defined: hazard logic as above.
- Undefined: hazard is tied to 0 and no bubbles are generated; an external hazard unit owns the stall.

Decomposition:
- Shared defines file gains: OPCODE_*, LOAD_*, STORE_*, and new MD_MUL..MD_REMU (funct3 values) plus FUNCT7_BASE/ALT/MEXT.
- One sub-module, decode_ctrl_comb: the pure combinational decode plus illegal and rs-used generation.
- The top level holds the register, handshake, hazard logic and counter.

Test Plan:
- Reset mid-stream: after rst_n low for 1 edge, out_valid = 0, md_busy = 0, load_type = LOAD_DEF, in_ready = 1.
- Load-use: lw x1,0(x0) (0x00002083), then add x2,x1,x1 (0x00108133), ex_ready = 1 → add accepted 2 cycles after lw with one bubble (out_valid = 0) between; with the macro off, no bubble.
- Divide: div x3,x1,x2 (0x0220C1B3), DIV_CYCLES = 33 → out_is_muldiv = 1, md_op = 100; md_busy high for 32 cycles after handoff; in_ready = 0 throughout; the next instruction is accepted on the first cycle md_busy = 0.
- Illegal store: 0x00003023 → out_illegal = 1, mem_write = 0, store_type = STORE_DEF, out_valid = 1.
- Backpressure: ex_ready = 0 for 5 cycles → all out_* stable and in_ready = 0; on release the entry hands off and a new instr is accepted in the same cycle.
- Flush with held entry and ex_ready = 0 → out_valid = 0 next cycle, in_ready = 0 during the flush cycle, a running divider counter keeps counting.
